// File: rtl/pushbutton_debouncer.sv
// -----------------------------------------------------------------------------
// pushbutton_debouncer
//
// Cleans up the board push-button. The raw, asynchronous, bouncing switch
// level goes through a two-flop synchroniser. A four-state FSM then accepts a
// level change only after the synchronised level has been stable for
// DEBOUNCE_CYCLES consecutive samples. The clean level feeds the LED-show
// stage. One-cycle press, release and long-press pulses feed control logic.
//
// Ports:
//   clock         in   sole clock, rising edge
//   resetN        in   synchronous active-low reset
//   rawButton     in   raw switch level, asynchronous, 1 = pressed
//   pushButton    out  debounced level, 1 = pressed (registered)
//   pressPulse    out  one-cycle pulse on an accepted press (registered)
//   releasePulse  out  one-cycle pulse on an accepted release (registered)
//   longPress     out  one-cycle pulse, at most once per accepted press
//                      (registered)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a change (>= 1)
//   HOLD_CYCLES      cycles a press must persist before longPress (>= 1)
//   COUNTER_WIDTH    width of both counters; must hold
//                    max(DEBOUNCE_CYCLES, HOLD_CYCLES) - 1
// -----------------------------------------------------------------------------
module pushbutton_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int COUNTER_WIDTH   = 8
) (
  input  logic clock,
  input  logic resetN,
  input  logic rawButton,
  output logic pushButton,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPress
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] DB_LAST   = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST = COUNTER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);

  logic                     sync1_q, sync2_q;
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] db_count_q, db_count_d;
  logic [COUNTER_WIDTH-1:0] hold_count_q, hold_count_d;
  logic                     long_done_q, long_done_d;

  logic push_q, push_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;

  // The FSM only ever looks at the second synchroniser stage.
  logic s;
  assign s = sync2_q;

  // ---------------------------------------------------------------------------
  // State register (synchroniser, FSM state, counters, registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  // The reset is checked inside the clocked block, so it only takes effect at
  // an edge. That makes it synchronous.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= RELEASED;
      db_count_q   <= '0;
      hold_count_q <= '0;
      long_done_q  <= 1'b0;
      push_q       <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      sync1_q      <= rawButton;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      db_count_q   <= db_count_d;
      hold_count_q <= hold_count_d;
      long_done_q  <= long_done_d;
      push_q       <= push_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    db_count_d   = db_count_q;
    hold_count_d = hold_count_q;
    long_done_d  = long_done_q;

    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d    = PRESS_WAIT;
          db_count_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (db_count_q == DB_LAST) begin
          state_d      = PRESSED;
          hold_count_d = '0;
          long_done_d  = 1'b0;
        end else begin
          db_count_d = db_count_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s) begin
          state_d    = RELEASE_WAIT;
          db_count_d = '0;
        end else if (!long_done_q) begin
          // The hold counter stops at its bound, so it never wraps.
          if (hold_count_q == HOLD_LAST) begin
            long_done_d = 1'b1;
          end else begin
            hold_count_d = hold_count_q + CNT_ONE;
          end
        end
      end

      RELEASE_WAIT: begin
        if (s) begin
          // A release bounce restarts the hold count. long_done is kept, so a
          // long press already reported is not reported again.
          state_d      = PRESSED;
          hold_count_d = '0;
        end else if (db_count_q == DB_LAST) begin
          state_d = RELEASED;
        end else begin
          db_count_d = db_count_q + CNT_ONE;
        end
      end

      default: state_d = RELEASED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. The outputs are computed from the transition being taken
  // and registered, so they change only at clock edges.
  // ---------------------------------------------------------------------------
  always_comb begin
    push_d    = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (state_q == PRESS_WAIT)   && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
    long_d    = (state_q == PRESSED) && s && !long_done_q && (hold_count_q == HOLD_LAST);
  end

  assign pushButton   = push_q;
  assign pressPulse   = press_q;
  assign releasePulse = release_q;
  assign longPress    = long_q;

endmodule

// File: doc/pushbutton_debouncer.md
# pushbutton_debouncer

Front-end conditioner for the board push-button. It takes the raw, asynchronous, bouncing switch level and synchronises and debounces it. It produces the clean `pushButton` level that drives the LED-show stage directly downstream, along with one-cycle press, release and long-press event pulses for control logic. All outputs are registered and change only on `clock` edges.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change. Must be ≥1.
- `HOLD_CYCLES`, default 16: cycles the debounced press must persist before `longPress` fires. Must be ≥1.
- `COUNTER_WIDTH`, default 8: width of both internal counters. Must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES)−1.

Ports:
- `clock`  in  1  sole clock, rising-edge.
- `resetN`  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `rawButton`  in  1  raw switch level, asynchronous, 1 = pressed.
- `pushButton`  out  1  debounced level, 1 = pressed.
- `pressPulse`  out  1  one-cycle pulse on an accepted press.
- `releasePulse`  out  1  one-cycle pulse on an accepted release.
- `longPress`  out  1  one-cycle pulse, at most once per accepted press.

## Operation
- **Synchroniser:** two flops, `rawButton → sync1 → sync2`. The FSM sees only `s = sync2`.
- **Debounce counter (`dbCount`) and hold counter (`holdCount`):** both COUNTER_WIDTH bits. Flag `longDone`.
- **RELEASED** (`pushButton` = 0):
  - s=1 → PRESS_WAIT, dbCount=0.
- **PRESS_WAIT** (`pushButton` = 0):
  - s=0 → RELEASED.
  - s=1 and dbCount==DEBOUNCE_CYCLES−1 → PRESSED. Register `pushButton`=1 and `pressPulse`=1. Set holdCount=0 and longDone=0.
  - Otherwise dbCount++.
- **PRESSED** (`pushButton` = 1):
  - s=0 → RELEASE_WAIT, dbCount=0.
  - Otherwise, if !longDone: when holdCount==HOLD_CYCLES−1, set `longPress`=1 and longDone=1; else holdCount++.
- **RELEASE_WAIT** (`pushButton` = 1):
  - s=1 → PRESSED, holdCount=0. longDone is kept. No pulse.
  - s=0 and dbCount==DEBOUNCE_CYCLES−1 → RELEASED. Register `pushButton`=0 and `releasePulse`=1.
  - Otherwise dbCount++.
- `pressPulse`, `releasePulse` and `longPress` default to 0 every cycle. They are high for exactly one cycle and are mutually exclusive.
- `longPress` never fires in RELEASE_WAIT. A release bounce restarts the hold count but cannot re-arm longPress.
- Counters never wrap: each is compared and cleared before reaching its bound.

## Timing
- **Reset:** at any edge with `resetN`=0, sync1, sync2, dbCount, holdCount and longDone are cleared, state goes to RELEASED, and all four outputs are 0. Reset has priority over every transition.
- **Reset mid-press:** `pushButton` drops to 0 at the reset edge with no `releasePulse`. If `rawButton` is still 1 after reset, a full press debounce runs and produces a new `pressPulse`.
- **Press latency:** let E0 be the first edge sampling `rawButton`=1, with the input stable thereafter. `pushButton` and `pressPulse` rise at edge E0+DEBOUNCE_CYCLES+2 (E6 at defaults).
- **Release latency:** symmetric. Release is accepted at F0+DEBOUNCE_CYCLES+2.
- **Long press:** with Ep the edge where `pushButton` rose and no bounce, `longPress` fires at Ep+HOLD_CYCLES (Ep+16 at defaults).
- **Glitch rejection:** a synchronised excursion lasting ≤DEBOUNCE_CYCLES−1 cycles produces no output change and no pulse. The state returns to its origin.
- **Simultaneous events:** an input change at the exact acceptance edge is ignored. The comparison uses the current `s`.

## Test plan
Defaults throughout.
- **Reset:** hold `resetN`=0 for 3 edges with `rawButton`=1 → all outputs 0 during reset. After reset, `pushButton` and `pressPulse` rise at the 7th edge sampling `rawButton`=1.
- **Clean press:** `rawButton` 0→1 at E0, held → `pushButton`=1 and a single-cycle `pressPulse` at E6. `longPress` is a single pulse at E22 and does not repeat through E60.
- **Press bounce:** `rawButton`=1 for 3 edges, 0 for 2, then 1 held → no output during the bounce. Exactly one `pressPulse`, 6 edges after the final rise.
- **Release bounce:** while pressed, `rawButton` low for 3 edges then high → `pushButton` stays 1, no `releasePulse`, and the hold count restarts. A subsequent stable low at F0 gives `pushButton`=0 and `releasePulse` at F6.
- **Short tap:** press held 10 edges after acceptance, then released → no `longPress`, one `pressPulse` and one `releasePulse`.
- **Reset mid-press:** assert `resetN`=0 for one edge 5 edges after `pressPulse`, with `rawButton` still 1 → `pushButton`=0 at the reset edge, no `releasePulse`. New `pressPulse` 7 edges after reset deasserts.
